// File: rtl/shift_reg_univ.sv
// WIDTH-bit universal shift register: hold, load, shift, rotate, arithmetic shift, clear,
// with a saturating shift counter. Define SHIFT_REG_SYNC_CLR_EN to add a synchronous clear port clr.
module shift_reg_univ #(
   parameter int               WIDTH     = 8,
   parameter int               CNT_W     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SHIFT_REG_SYNC_CLR_EN
   input  logic             clr,
`endif
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] data,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             sout_l,
   output logic             sout_r,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             drained
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_LOAD  = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_SHR   = 3'b011,
      MODE_ROL   = 3'b100,
      MODE_ROR   = 3'b101,
      MODE_ASR   = 3'b110,
      MODE_CLEAR = 3'b111
   } mode_e;

   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drained_q, drained_d;
   logic             is_shift;
   mode_e            mode_sel;

   assign mode_sel = mode_e'(mode);

   always_comb begin
      q_d       = q_q;
      cnt_d     = cnt_q;
      drained_d = drained_q;
      is_shift  = 1'b0;
`ifdef SHIFT_REG_SYNC_CLR_EN
      if (clr) begin
         q_d       = '0;
         cnt_d     = '0;
         drained_d = 1'b0;
      end else
`endif
      if (en) begin
         case (mode_sel)
            MODE_HOLD:  q_d = q_q;
            MODE_LOAD:  begin
               q_d   = data;
               cnt_d = '0;
            end
            MODE_SHL:   begin
               q_d      = {q_q[WIDTH-2:0], sin_r};
               is_shift = 1'b1;
            end
            MODE_SHR:   begin
               q_d      = {sin_l, q_q[WIDTH-1:1]};
               is_shift = 1'b1;
            end
            MODE_ROL:   begin
               q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               is_shift = 1'b1;
            end
            MODE_ROR:   begin
               q_d      = {q_q[0], q_q[WIDTH-1:1]};
               is_shift = 1'b1;
            end
            MODE_ASR:   begin
               q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
               is_shift = 1'b1;
            end
            MODE_CLEAR: begin
               q_d   = '0;
               cnt_d = '0;
            end
         endcase
         // Counter saturates rather than wrapping so drained stays asserted on long streams
         if (is_shift && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
         end
         drained_d = (cnt_d >= WIDTH_CNT);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q       <= RESET_VAL;
         cnt_q     <= '0;
         drained_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         drained_q <= drained_d;
      end
   end

   assign q         = q_q;
   assign qbar      = ~q_q;
   assign sout_l    = q_q[WIDTH-1];
   assign sout_r    = q_q[0];
   assign shift_cnt = cnt_q;
   assign drained   = drained_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8, CNT_W=4) using an arithmetic reference model.
// Build with SHIFT_REG_SYNC_CLR_EN defined to exercise the synchronous clear port.
module tb_shift_reg_univ;

   logic       clk;
   logic       reset;
   logic       clr;
   logic       en;
   logic [2:0] mode;
   logic [7:0] data;
   logic       sin_l;
   logic       sin_r;
   logic [7:0] q;
   logic [7:0] qbar;
   logic       sout_l;
   logic       sout_r;
   logic [3:0] shift_cnt;
   logic       drained;

   int total;
   int bad;

   // Reference model state: register value as an integer 0..255, counter 0..15
   int mq;
   int mc;
   bit md;

   shift_reg_univ #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef SHIFT_REG_SYNC_CLR_EN
      .clr       (clr),
`endif
      .en        (en),
      .mode      (mode),
      .data      (data),
      .sin_l     (sin_l),
      .sin_r     (sin_r),
      .q         (q),
      .qbar      (qbar),
      .sout_l    (sout_l),
      .sout_r    (sout_r),
      .shift_cnt (shift_cnt),
      .drained   (drained)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      mq = 0;
      mc = 0;
      md = 1'b0;
   endtask

   // Apply one operation at the falling edge, clock it in, then update the model
   task automatic do_op(input bit e, input int m, input int d, input bit sl, input bit sr, input bit c);
      @(negedge clk);
      en    = e;
      mode  = 3'(m);
      data  = 8'(d);
      sin_l = sl;
      sin_r = sr;
      clr   = c;
      @(posedge clk);
      #1;
`ifdef SHIFT_REG_SYNC_CLR_EN
      if (c) begin
         mq = 0;
         mc = 0;
         md = 1'b0;
         return;
      end
`endif
      if (e) begin
         case (m)
            1: begin mq = d % 256; mc = 0; end
            2: mq = (mq * 2 + sr) % 256;
            3: mq = mq / 2 + (sl ? 128 : 0);
            4: mq = (mq * 2) % 256 + mq / 128;
            5: mq = mq / 2 + (mq % 2) * 128;
            6: mq = mq / 2 + (mq >= 128 ? 128 : 0);
            7: begin mq = 0; mc = 0; end
            default: mq = mq;
         endcase
         if (m >= 2 && m <= 6) mc = (mc < 15) ? mc + 1 : 15;
         md = (mc >= 8);
      end
   endtask

   task automatic test_reset();
      logic [7:0] exp_q;
      do_op(1, 1, 8'hA5, 0, 0, 0);
      exp_q = 8'(mq);
      total++;
      if (q !== exp_q) begin
         bad++;
         $display("[TB] FAIL reset_preload q got=%h want=%h", q, exp_q);
      end
      #2 reset = 1'b1;
      #1;
      model_reset();
      total++;
      if (q !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_async_q got=%h want=00", q);
      end
      total++;
      if (qbar !== 8'hFF) begin
         bad++;
         $display("[TB] FAIL reset_async_qbar got=%h want=ff", qbar);
      end
      total++;
      if (shift_cnt !== 4'd0 || drained !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_cnt_drained got=%0d/%b want=0/0", shift_cnt, drained);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_shift_left();
      bit exp_sout[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      do_op(1, 1, 8'hA5, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (sout_l !== exp_sout[i] || sout_l !== 1'(mq / 128)) begin
            bad++;
            $display("[TB] FAIL shl_sout_l step=%0d got=%b want=%b", i, sout_l, exp_sout[i]);
         end
         total++;
         if (drained !== 1'b0) begin
            bad++;
            $display("[TB] FAIL shl_drained_early step=%0d got=%b want=0", i, drained);
         end
         do_op(1, 2, 0, 0, 1, 0);
      end
      total++;
      if (q !== 8'hFF || 8'(mq) !== 8'hFF) begin
         bad++;
         $display("[TB] FAIL shl_final_q got=%h want=ff", q);
      end
      total++;
      if (shift_cnt !== 4'd8 || drained !== 1'b1) begin
         bad++;
         $display("[TB] FAIL shl_final_cnt got=%0d/%b want=8/1", shift_cnt, drained);
      end
   endtask

   task automatic test_rotate();
      logic [7:0] exp_seq[8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
      do_op(1, 1, 8'h81, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         do_op(1, 5, 0, 0, 0, 0);
         total++;
         if (q !== exp_seq[i] || q !== 8'(mq)) begin
            bad++;
            $display("[TB] FAIL ror_step=%0d got=%h want=%h", i, q, exp_seq[i]);
         end
      end
      total++;
      if (shift_cnt !== 4'd8) begin
         bad++;
         $display("[TB] FAIL ror_cnt got=%0d want=8", shift_cnt);
      end
   endtask

   task automatic test_arith();
      do_op(1, 1, 8'h80, 0, 0, 0);
      for (int i = 0; i < 3; i++) do_op(1, 6, 0, 0, 0, 0);
      total++;
      if (q !== 8'hF0) begin
         bad++;
         $display("[TB] FAIL asr_q got=%h want=f0", q);
      end
      total++;
      if (shift_cnt !== 4'd3 || drained !== 1'b0) begin
         bad++;
         $display("[TB] FAIL asr_cnt got=%0d/%b want=3/0", shift_cnt, drained);
      end
   endtask

   task automatic test_enable_saturation();
      logic [7:0] held_q;
      logic [3:0] held_c;
      held_q = 8'(mq);
      held_c = 4'(mc);
      for (int i = 0; i < 5; i++) do_op(0, 2, $urandom, 1, 1, 0);
      total++;
      if (q !== held_q || shift_cnt !== held_c) begin
         bad++;
         $display("[TB] FAIL en_hold got=%h/%0d want=%h/%0d", q, shift_cnt, held_q, held_c);
      end
      for (int i = 0; i < 20; i++) begin
         do_op(1, 2, 0, 0, 1'($urandom), 0);
         if (i >= 8) begin
            total++;
            if (drained !== 1'b1) begin
               bad++;
               $display("[TB] FAIL sat_drained step=%0d got=%b want=1", i, drained);
            end
         end
      end
      total++;
      if (shift_cnt !== 4'd15) begin
         bad++;
         $display("[TB] FAIL sat_cnt got=%0d want=15", shift_cnt);
      end
      do_op(1, 1, 8'h5A, 0, 0, 0);
      total++;
      if (shift_cnt !== 4'd0 || drained !== 1'b0 || q !== 8'h5A) begin
         bad++;
         $display("[TB] FAIL load_after_sat got=%0d/%b/%h want=0/0/5a", shift_cnt, drained, q);
      end
   endtask

   task automatic test_clr();
      logic [7:0] exp_q;
      do_op(1, 2, 0, 0, 1, 0);
      do_op(1, 1, 8'h3C, 0, 0, 1);
`ifdef SHIFT_REG_SYNC_CLR_EN
      exp_q = 8'h00;
`else
      exp_q = 8'h3C;
`endif
      total++;
      if (q !== exp_q || shift_cnt !== 4'd0) begin
         bad++;
         $display("[TB] FAIL clr_load got=%h/%0d want=%h/0", q, shift_cnt, exp_q);
      end
      do_op(1, 7, 0, 0, 0, 0);
      total++;
      if (q !== 8'h00 || drained !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mode_clear got=%h/%b want=00/0", q, drained);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_q;
      for (int i = 0; i < 300; i++) begin
         do_op(($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
               1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
         exp_q = 8'(mq);
         total++;
         if (q !== exp_q || qbar !== ~exp_q || sout_l !== exp_q[7] || sout_r !== exp_q[0]
             || shift_cnt !== 4'(mc) || drained !== md) begin
            bad++;
            $display("[TB] FAIL random step=%0d got q=%h qb=%h sl=%b sr=%b c=%0d d=%b want q=%h c=%0d d=%b",
                     i, q, qbar, sout_l, sout_r, shift_cnt, drained, exp_q, mc, md);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      clr   = 1'b0;
      en    = 1'b0;
      mode  = 3'b000;
      data  = 8'h00;
      sin_l = 1'b0;
      sin_r = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      total++;
      if (q !== 8'h00 || shift_cnt !== 4'd0 || drained !== 1'b0) begin
         bad++;
         $display("[TB] FAIL power_on_reset got=%h/%0d/%b want=00/0/0", q, shift_cnt, drained);
      end
      reset = 1'b0;
      test_reset();
      test_shift_left();
      test_rotate();
      test_arith();
      test_enable_saturation();
      test_clr();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
